// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Write-back stage. Holds the MEM/WB pipeline register, selects the
//            ALU result or load data, and drives the register-file write port.
//            Supports stall and flush. Keeps a record of the last committed
//            write for the DDU. The optional retired-instruction counter is
//            enabled with the WB_RETIRE_CNT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Valid_mem,
    input  logic          RegWrite_mem,
    input  logic          MemtoReg_mem,
    input  logic [AW-1:0] RegWriteAddr_mem,
    input  logic [DW-1:0] ALUResult_mem,
    input  logic [DW-1:0] MemData_mem,
    input  logic          Stall_wb,
    input  logic          Flush_wb,
    output logic          RegWrite_wb,
    output logic [AW-1:0] RegWriteAddr_wb,
    output logic [DW-1:0] RegWriteData_wb,
    output logic          Valid_wb,
    output logic [AW-1:0] DDU_lastaddr,
    output logic [DW-1:0] DDU_lastdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]   RetireCnt
`endif
);

    logic          r_valid;
    logic          r_regwrite;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_ddu_addr;
    logic [DW-1:0] r_ddu_data;

    logic [DW-1:0] w_wb_data;
    logic          w_regwrite;
    logic          w_commit;

    // Select write-back data and qualify the write enable ahead of the register;
    // a write to register 0 is suppressed but its address/data are still kept.
    always_comb begin
        w_wb_data  = MemtoReg_mem ? MemData_mem : ALUResult_mem;
        w_regwrite = RegWrite_mem & Valid_mem & (RegWriteAddr_mem != '0);
        w_commit   = r_regwrite & ~Stall_wb;
    end

    // MEM/WB pipeline register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else if (Flush_wb) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else if (!Stall_wb) begin
            r_valid    <= Valid_mem;
            r_regwrite <= w_regwrite;
            r_addr     <= RegWriteAddr_mem;
            r_data     <= w_wb_data;
        end
    end

    // Record the write only on the unstalled edge, so each instruction commits once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ddu_addr <= '0;
            r_ddu_data <= '0;
        end else if (w_commit) begin
            r_ddu_addr <= r_addr;
            r_ddu_data <= r_data;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // Count each valid instruction leaving WB once; flush only kills the entrant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !Stall_wb) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign RetireCnt = r_retire_cnt;
`endif

    assign Valid_wb        = r_valid;
    assign RegWrite_wb     = r_regwrite;
    assign RegWriteAddr_wb = r_addr;
    assign RegWriteData_wb = r_data;
    assign DDU_lastaddr    = r_ddu_addr;
    assign DDU_lastdata    = r_ddu_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage with a behavioural model of the
//            write-back slot, the DDU record and the retire count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int VW = 2 + 2 * AW + 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          Valid_mem, RegWrite_mem, MemtoReg_mem;
    logic [AW-1:0] RegWriteAddr_mem;
    logic [DW-1:0] ALUResult_mem, MemData_mem;
    logic          Stall_wb, Flush_wb;
    logic          RegWrite_wb, Valid_wb;
    logic [AW-1:0] RegWriteAddr_wb, DDU_lastaddr;
    logic [DW-1:0] RegWriteData_wb, DDU_lastdata;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]   RetireCnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic          m_valid, m_we;
    logic [AW-1:0] m_addr, m_ddu_a;
    logic [DW-1:0] m_data, m_ddu_d;
    logic [31:0]   m_cnt;

    wb_stage #(.DW(DW), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .Valid_mem        (Valid_mem),
        .RegWrite_mem     (RegWrite_mem),
        .MemtoReg_mem     (MemtoReg_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem),
        .ALUResult_mem    (ALUResult_mem),
        .MemData_mem      (MemData_mem),
        .Stall_wb         (Stall_wb),
        .Flush_wb         (Flush_wb),
        .RegWrite_wb      (RegWrite_wb),
        .RegWriteAddr_wb  (RegWriteAddr_wb),
        .RegWriteData_wb  (RegWriteData_wb),
        .Valid_wb         (Valid_wb),
        .DDU_lastaddr     (DDU_lastaddr),
        .DDU_lastdata     (DDU_lastdata)
`ifdef WB_RETIRE_CNT_EN
        ,
        .RetireCnt        (RetireCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] obs_vec();
        return {Valid_wb, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, DDU_lastaddr, DDU_lastdata};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_valid, m_we, m_addr, m_data, m_ddu_a, m_ddu_d};
    endfunction

    function automatic logic [31:0] obs_cnt();
`ifdef WB_RETIRE_CNT_EN
        return RetireCnt;
`else
        return m_cnt;
`endif
    endfunction

    task automatic set_in(input logic v, input logic rw, input logic mtr, input logic [AW-1:0] a,
                          input logic [DW-1:0] alu, input logic [DW-1:0] md,
                          input logic st, input logic fl);
        Valid_mem = v; RegWrite_mem = rw; MemtoReg_mem = mtr; RegWriteAddr_mem = a;
        ALUResult_mem = alu; MemData_mem = md; Stall_wb = st; Flush_wb = fl;
    endtask

    task automatic rand_mem();
        Valid_mem        = 1'($urandom);
        RegWrite_mem     = 1'($urandom);
        MemtoReg_mem     = 1'($urandom);
        RegWriteAddr_mem = AW'($urandom);
        ALUResult_mem    = $urandom;
        MemData_mem      = $urandom;
    endtask

    // One clock edge: the model applies the rules to the inputs present at the
    // edge, then outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_we = 0; m_addr = '0; m_data = '0;
            m_ddu_a = '0; m_ddu_d = '0; m_cnt = '0;
        end else begin
            if (m_we && !Stall_wb) begin
                m_ddu_a = m_addr;
                m_ddu_d = m_data;
            end
            if (m_valid && !Stall_wb) m_cnt = m_cnt + 1;
            if (Flush_wb) begin
                m_valid = 0; m_we = 0; m_addr = '0; m_data = '0;
            end else if (!Stall_wb) begin
                m_valid = Valid_mem;
                m_we    = Valid_mem && RegWrite_mem && (RegWriteAddr_mem != 0);
                m_addr  = RegWriteAddr_mem;
                m_data  = MemtoReg_mem ? MemData_mem : ALUResult_mem;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_mem();
            Stall_wb = 1'($urandom); Flush_wb = 1'($urandom);
            tick();
            total++;
            if (obs_vec() !== {VW{1'b0}} || obs_cnt() !== 32'd0) begin
                bad++;
                $display("FAIL reset: got %h cnt=%h expected 0", obs_vec(), obs_cnt());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_write();
        set_in(1, 1, 0, 5'd5, 32'h1234, 32'hDEAD, 0, 0);
        tick();
        total++;
        if (RegWrite_wb !== 1'b1 || RegWriteAddr_wb !== 5'd5 || RegWriteData_wb !== 32'h1234) begin
            bad++;
            $display("FAIL alu_write: got we=%b a=%0d d=%h expected we=1 a=5 d=1234",
                     RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb);
        end
        set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        tick();
        total++;
        if (DDU_lastaddr !== 5'd5 || DDU_lastdata !== 32'h1234 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL alu_ddu: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_load_zero();
        set_in(1, 1, 1, 5'd7, 32'h1111, 32'hCAFEF00D, 0, 0);
        tick();
        total++;
        if (RegWrite_wb !== 1'b1 || RegWriteData_wb !== 32'hCAFEF00D || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL load_write: got %h expected %h", obs_vec(), exp_vec());
        end
        set_in(1, 1, 0, 5'd0, 32'h2222, 32'h3333, 0, 0);
        tick();
        total++;
        if (RegWrite_wb !== 1'b0 || Valid_wb !== 1'b1 || RegWriteData_wb !== 32'h2222) begin
            bad++;
            $display("FAIL reg0_protect: got we=%b v=%b d=%h expected we=0 v=1 d=2222",
                     RegWrite_wb, Valid_wb, RegWriteData_wb);
        end
        set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        tick();
        total++;
        if (DDU_lastaddr !== 5'd7 || DDU_lastdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL reg0_ddu: got a=%0d d=%h expected a=7 d=cafef00d", DDU_lastaddr, DDU_lastdata);
        end
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        set_in(1, 1, 0, 5'd3, 32'h55, 32'h99, 0, 0);
        tick();
        c0 = obs_cnt();
        for (int i = 0; i < 3; i++) begin
            rand_mem();
            Stall_wb = 1'b1; Flush_wb = 1'b0;
            tick();
            total++;
            if (RegWriteAddr_wb !== 5'd3 || RegWriteData_wb !== 32'h55 || RegWrite_wb !== 1'b1 ||
                obs_vec() !== exp_vec() || obs_cnt() !== c0) begin
                bad++;
                $display("FAIL stall_hold: got %h cnt=%h expected %h cnt=%h", obs_vec(), obs_cnt(), exp_vec(), c0);
            end
        end
        set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        tick();
        total++;
        if (DDU_lastaddr !== 5'd3 || DDU_lastdata !== 32'h55 || obs_cnt() !== c0 + 32'd1) begin
            bad++;
            $display("FAIL stall_commit: got a=%0d d=%h cnt=%h expected a=3 d=55 cnt=%h",
                     DDU_lastaddr, DDU_lastdata, obs_cnt(), c0 + 32'd1);
        end
    endtask

    task automatic test_flush_stall();
        logic [31:0] c0;
        set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        tick();
        c0 = obs_cnt();
        set_in(1, 1, 0, 5'd9, 32'hABCD, 32'h0, 1, 1);
        tick();
        total++;
        if (Valid_wb !== 1'b0 || RegWrite_wb !== 1'b0 || obs_cnt() !== c0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL flush_stall: got %h cnt=%h expected %h cnt=%h", obs_vec(), obs_cnt(), exp_vec(), c0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_mem();
            Stall_wb = ($urandom_range(0, 3) == 0);
            Flush_wb = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 39) == 0);
            tick();
            total++;
            if (obs_vec() !== exp_vec() || obs_cnt() !== m_cnt) begin
                bad++;
                $display("FAIL random[%0d]: got %h cnt=%h expected %h cnt=%h",
                         i, obs_vec(), obs_cnt(), exp_vec(), m_cnt);
            end
        end
        rst = 1'b0;
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_wrap();
        set_in(1, 1, 0, 5'd4, 32'h77, 32'h0, 0, 0);
        tick();
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        tick();
        total++;
        if (RetireCnt !== 32'd0) begin
            bad++;
            $display("FAIL cnt_wrap: got %h expected 00000000", RetireCnt);
        end
    endtask
`endif

    initial begin
        set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        #2;
        test_reset();
        test_alu_write();
        test_load_zero();
        test_stall();
        test_flush_stall();
        test_random();
`ifdef WB_RETIRE_CNT_EN
        test_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline CPU. It holds the MEM/WB pipeline register, selects the ALU result or the load data as write-back data, and drives the register-file write port of the decode stage (RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb). It also supports stall and flush from hazard control, keeps a debug record of the last committed write for the DDU, and optionally counts retired instructions.

## Interface
Parameters:
- DW, 32: data width.
- AW, 5: register address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- Valid_mem  in  1  MEM stage holds a real instruction, not a bubble.
- RegWrite_mem  in  1  instruction writes the register file.
- MemtoReg_mem  in  1  1 = write load data, 0 = write ALU result.
- RegWriteAddr_mem  in  AW  destination register.
- ALUResult_mem  in  DW  ALU result from MEM.
- MemData_mem  in  DW  data-memory read data from MEM.
- Stall_wb  in  1  hold the MEM/WB register.
- Flush_wb  in  1  load a bubble into the MEM/WB register.
- RegWrite_wb  out  1  register-file write enable to ID.
- RegWriteAddr_wb  out  AW  write address to ID.
- RegWriteData_wb  out  DW  write data to ID.
- Valid_wb  out  1  WB holds a real instruction.
- DDU_lastaddr  out  AW  address of the last committed register write.
- DDU_lastdata  out  DW  data of the last committed register write.
- RetireCnt  out  32  retired-instruction count. Present only with WB_RETIRE_CNT_EN.

## Operation
- Update priority each edge: rst > Flush_wb > Stall_wb > load.
- rst:
  - All registers clear to 0.
  - Valid_wb=0, RegWrite_wb=0, RegWriteAddr_wb=0, RegWriteData_wb=0.
  - DDU_lastaddr=0, DDU_lastdata=0, RetireCnt=0.
- Flush_wb=1:
  - Valid and RegWrite registers clear to 0.
  - Address and data registers also clear to 0.
- Stall_wb=1 (no flush): all MEM/WB registers hold their values.
- Load (no rst, flush or stall):
  - Stored data = MemtoReg_mem ? MemData_mem : ALUResult_mem. The mux is in front of the register.
  - Stored Valid = Valid_mem.
  - Stored RegWrite = RegWrite_mem & Valid_mem & (RegWriteAddr_mem != 0).
- $0 protection: an instruction targeting register 0 never asserts RegWrite_wb. Its address and data are still stored.
- Committed write: a cycle with RegWrite_wb=1 and Stall_wb=0. On that edge, DDU_lastaddr/DDU_lastdata latch RegWriteAddr_wb/RegWriteData_wb.
- During a stall, RegWrite_wb stays asserted. The repeated write of the same value to the register file is harmless. DDU registers do not update while stalled, so each instruction commits exactly once.
- No arithmetic on the data path. Data width is DW throughout, with no extension or truncation.

## Timing
- Latency: 1 cycle from MEM inputs to WB outputs. All outputs are registered; there are no combinational input-to-output paths.
- The register file writes on the same edge that ends the WB cycle. The ID read-after-write bypass is handled outside this block.
- DDU_lastaddr/DDU_lastdata lag RegWrite_wb by one edge.
- Flush and Stall in the same cycle: flush wins and a bubble is loaded.
- Reset asserted mid-stall or mid-flush: reset wins, and everything is 0 on the next cycle.
- Reset deasserted: loading resumes on the first edge with rst=0.

## Configuration
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - RetireCnt increments by 1 on each edge with Valid_wb=1 and Stall_wb=0. This counts bubbles-excluded retirements and counts stalled instructions once.
  - RetireCnt wraps from 0xFFFFFFFF to 0.
  - RetireCnt clears on rst. It is not affected by Flush_wb, which only kills the instruction entering WB.
- Undefined: the counter logic and the RetireCnt port are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0. With macro, RetireCnt=0.
- ALU write: Valid=1, RegWrite=1, MemtoReg=0, addr=5, ALU=0x1234, MemData=0xDEAD -> next cycle RegWrite_wb=1, addr=5, data=0x1234. One cycle later DDU_lastaddr=5, DDU_lastdata=0x1234.
- Load write and $0: MemtoReg=1, addr=7, MemData=0xCAFEF00D -> data=0xCAFEF00D, RegWrite_wb=1. Then addr=0 -> RegWrite_wb=0 and DDU registers unchanged.
- Stall: load addr=3 data=0x55, then Stall_wb=1 for 3 cycles with new inputs -> outputs held at addr 3/0x55. DDU updates once. RetireCnt increments once.
- Flush vs stall: Flush_wb=1 and Stall_wb=1 together with a valid write input -> next cycle Valid_wb=0, RegWrite_wb=0, RetireCnt unchanged.
- Counter wrap (macro defined): force RetireCnt to 0xFFFFFFFF, retire one valid instruction -> RetireCnt=0.
